seg7_scan_driver: RTL and testbench



---
 rtl/seg7_pkg.sv | 26 ++
 rtl/seg7_decode.sv | 14 +
 rtl/seg7_scan_driver.sv | 152 +++++++++++++++
 tb/tb_seg7_scan_driver.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment display blocks.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned BCD_W      = 4 * NUM_DIGITS;

  localparam logic [SEG_W-1:0] SEG_OFF = 7'b1111111;

  // Active-low {g,f,e,d,c,b,a} patterns for digits 0..9
  localparam logic [0:9][SEG_W-1:0] SEG_DIGIT = {
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  typedef enum logic {
    ST_ACTIVE = 1'b0,
    ST_BLANK  = 1'b1
  } scan_state_t;

  typedef struct packed {
    logic [BCD_W-1:0]      bcd;
    logic [NUM_DIGITS-1:0] dp;
  } seg7_frame_t;

endpackage

// File: rtl/seg7_decode.sv
// Nibble to active-low cathode pattern; non-decimal nibbles are blank.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_OFF;
    if (nibble < 4'd10) seg_c = SEG_DIGIT[nibble];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// 4-digit multiplexed 7-segment driver with frame-synchronous update,
// inter-digit blanking, leading-zero suppression and decimal points.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 400,
  parameter int unsigned BLANK_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BCD_W-1:0]      bcd_in,
  input  logic                  bcd_valid,
  input  logic [NUM_DIGITS-1:0] dp_in,
  input  logic                  blank_lz,
  output logic [SEG_W-1:0]      seg_cathode,
  output logic                  seg_dp,
  output logic [NUM_DIGITS-1:0] seg_anode,
  output logic                  frame_done
);

  localparam int unsigned PHASE_W = 17;
  localparam int unsigned IDX_W   = 2;

  scan_state_t        state, state_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [PHASE_W-1:0] phase, phase_n;

  seg7_frame_t pend, disp, disp_n;
  logic        pend_flag;
  logic        frame_start_c;

  logic [3:0]       nib_c;
  logic             dp_bit_c;
  logic             suppress_c;
  logic [2:0]       zero_c;
  logic [SEG_W-1:0] dec_c;

  // Scan sequencing; outputs are registered from the next-state values so
  // they line up with the state in the same cycle.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    phase_n = phase + PHASE_W'(1);
    case (state)
      ST_ACTIVE: begin
        if (phase == PHASE_W'(REFRESH_DIV - 1)) begin
          state_n = ST_BLANK;
          phase_n = '0;
        end
      end
      ST_BLANK: begin
        if (phase == PHASE_W'(BLANK_CYCLES - 1)) begin
          state_n = ST_ACTIVE;
          phase_n = '0;
          idx_n   = idx + IDX_W'(1);
        end
      end
      default: begin
        state_n = ST_BLANK;
        phase_n = '0;
      end
    endcase
  end

  assign frame_start_c = (state == ST_BLANK) && (idx == IDX_W'(NUM_DIGITS - 1)) &&
                         (phase == PHASE_W'(BLANK_CYCLES - 1));

  // A strobe coinciding with the frame boundary bypasses the pending register
  always_comb begin
    disp_n = disp;
    if (frame_start_c) begin
      if (bcd_valid)      disp_n = '{bcd: bcd_in, dp: dp_in};
      else if (pend_flag) disp_n = pend;
    end
  end

  assign zero_c[0] = (disp_n.bcd[15:12] == 4'd0);
  assign zero_c[1] = (disp_n.bcd[11:8]  == 4'd0);
  assign zero_c[2] = (disp_n.bcd[7:4]   == 4'd0);

  always_comb begin
    nib_c      = disp_n.bcd[3:0];
    dp_bit_c   = disp_n.dp[0];
    suppress_c = 1'b0;
    case (idx_n)
      2'd0: begin
        nib_c      = disp_n.bcd[15:12];
        dp_bit_c   = disp_n.dp[3];
        suppress_c = zero_c[0];
      end
      2'd1: begin
        nib_c      = disp_n.bcd[11:8];
        dp_bit_c   = disp_n.dp[2];
        suppress_c = zero_c[0] & zero_c[1];
      end
      2'd2: begin
        nib_c      = disp_n.bcd[7:4];
        dp_bit_c   = disp_n.dp[1];
        suppress_c = &zero_c;
      end
      default: begin
        nib_c      = disp_n.bcd[3:0];
        dp_bit_c   = disp_n.dp[0];
        suppress_c = 1'b0;
      end
    endcase
  end

  seg7_decode u_decode (
    .nibble (nib_c),
    .seg_c  (dec_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_BLANK;
      idx         <= IDX_W'(NUM_DIGITS - 1);
      phase       <= '0;
      pend        <= '0;
      pend_flag   <= 1'b0;
      disp        <= '0;
      seg_anode   <= '1;
      seg_cathode <= SEG_OFF;
      seg_dp      <= 1'b1;
      frame_done  <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      phase      <= phase_n;
      disp       <= disp_n;
      frame_done <= frame_start_c;

      if (frame_start_c) begin
        pend_flag <= 1'b0;
      end else if (bcd_valid) begin
        pend      <= '{bcd: bcd_in, dp: dp_in};
        pend_flag <= 1'b1;
      end

      if (state_n == ST_ACTIVE) begin
        seg_anode   <= ~(4'b1000 >> idx_n);
        seg_cathode <= (blank_lz && suppress_c) ? SEG_OFF : dec_c;
        seg_dp      <= ~dp_bit_c;
      end else begin
        seg_anode   <= '1;
        seg_cathode <= SEG_OFF;
        seg_dp      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with a 4-cycle digit / 2-cycle blank scan.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] bcd_in;
  logic        bcd_valid;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [6:0]  seg_cathode;
  logic        seg_dp;
  logic [3:0]  seg_anode;
  logic        frame_done;

  int tests_run = 0;
  int tests_failed = 0;

  localparam logic [6:0] B  = 7'b1111111;
  localparam logic [6:0] D0 = 7'b1000000;
  localparam logic [6:0] D1 = 7'b1111001;
  localparam logic [6:0] D2 = 7'b0100100;
  localparam logic [6:0] D3 = 7'b0110000;
  localparam logic [6:0] D4 = 7'b0011001;
  localparam logic [6:0] D5 = 7'b0010010;
  localparam logic [6:0] D6 = 7'b0000010;
  localparam logic [6:0] D7 = 7'b1111000;
  localparam logic [6:0] D8 = 7'b0000000;
  localparam logic [6:0] D9 = 7'b0010000;

  localparam logic [12:0] ALL_OFF = {4'b1111, 7'b1111111, 1'b1, 1'b0};

  typedef struct packed {
    logic            lz;
    logic [15:0]     bcd;
    logic [3:0]      dp;
    logic [0:3][6:0] cath;
  } vec_t;

  vec_t vecs [7];

  seg7_scan_driver #(.REFRESH_DIV(4), .BLANK_CYCLES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .bcd_in      (bcd_in),
    .bcd_valid   (bcd_valid),
    .dp_in       (dp_in),
    .blank_lz    (blank_lz),
    .seg_cathode (seg_cathode),
    .seg_dp      (seg_dp),
    .seg_anode   (seg_anode),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [12:0] act, input logic [12:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got anode/cath/dp/fd=%b required %b", name, act, exp);
    end
  endtask

  function automatic logic [12:0] outs();
    return {seg_anode, seg_cathode, seg_dp, frame_done};
  endfunction

  // Advance to the next frame_done sample; n = negedges consumed.
  task automatic wait_frame(output int n);
    n = 0;
    do begin
      @(negedge clk);
      bcd_valid = 1'b0;
      n++;
    end while (frame_done !== 1'b1 && n < 100);
    if (frame_done !== 1'b1) begin
      tests_run++;
      tests_failed++;
      $display("FAIL wait_frame: no frame_done within %0d cycles", n);
    end
  endtask

  // Check a whole frame starting at its frame_done sample, with optional strobes.
  task automatic check_frame(input string name, input logic [0:3][6:0] cath, input logic [3:0] dpe,
                             input int s1, input logic [15:0] v1,
                             input int s2, input logic [15:0] v2);
    for (int t = 0; t < 24; t++) begin
      int d;
      logic [12:0] e;
      d = t / 6;
      if ((t % 6) < 4) e = {~(4'b1000 >> d), cath[d], ~dpe[3-d], (t == 0)};
      else             e = ALL_OFF;
      chk($sformatf("%s t=%0d", name, t), outs(), e);
      if (t == s1 + 1 || t == s2 + 1) bcd_valid = 1'b0;
      if (t == s1) begin bcd_in = v1; bcd_valid = 1'b1; end
      if (t == s2) begin bcd_in = v2; bcd_valid = 1'b1; end
      if (t < 23) @(negedge clk);
    end
  endtask

  // Release reset just after a posedge and check the two leading blank cycles.
  task automatic release_and_check(input string name);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk({name, " blank1"}, outs(), ALL_OFF);
    @(negedge clk);
    chk({name, " blank2"}, outs(), ALL_OFF);
    @(negedge clk);
  endtask

  initial begin
    int n;
    vecs[0] = '{lz: 1'b0, bcd: 16'h1234, dp: 4'b0000, cath: {D1, D2, D3, D4}};
    vecs[1] = '{lz: 1'b1, bcd: 16'h0045, dp: 4'b0000, cath: {B,  B,  D4, D5}};
    vecs[2] = '{lz: 1'b1, bcd: 16'h0000, dp: 4'b0000, cath: {B,  B,  B,  D0}};
    vecs[3] = '{lz: 1'b1, bcd: 16'h0405, dp: 4'b0000, cath: {B,  D4, D0, D5}};
    vecs[4] = '{lz: 1'b0, bcd: 16'hA0B9, dp: 4'b0010, cath: {B,  D0, B,  D9}};
    vecs[5] = '{lz: 1'b1, bcd: 16'hA0B9, dp: 4'b1001, cath: {B,  D0, B,  D9}};
    vecs[6] = '{lz: 1'b0, bcd: 16'h9999, dp: 4'b0000, cath: {D9, D9, D9, D9}};

    reset = 1'b1; bcd_in = '0; bcd_valid = 1'b0; dp_in = '0; blank_lz = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_values", outs(), ALL_OFF);

    release_and_check("first");
    check_frame("first_zero", {D0, D0, D0, D0}, 4'b0000, -10, 16'h0, -10, 16'h0);

    foreach (vecs[i]) begin
      @(negedge clk);
      blank_lz = vecs[i].lz; dp_in = vecs[i].dp; bcd_in = vecs[i].bcd; bcd_valid = 1'b1;
      @(negedge clk);
      bcd_valid = 1'b0;
      wait_frame(n);
      tests_run++;
      if (n != 23) begin
        tests_failed++;
        $display("FAIL period vec%0d: got %0d cycles required 23", i, n);
      end
      check_frame($sformatf("vec%0d", i), vecs[i].cath, vecs[i].dp, -10, 16'h0, -10, 16'h0);
    end

    // Mid-frame strobes must not tear the current frame
    dp_in = '0; blank_lz = 1'b0;
    wait_frame(n);
    check_frame("tear_9999", {D9, D9, D9, D9}, 4'b0000, 7, 16'h1111, -10, 16'h0);
    wait_frame(n);
    check_frame("tear_1111", {D1, D1, D1, D1}, 4'b0000, 3, 16'h2222, 15, 16'h3333);
    wait_frame(n);
    check_frame("last_wins", {D3, D3, D3, D3}, 4'b0000, 23, 16'h5678, -10, 16'h0);
    wait_frame(n);
    check_frame("edge_load", {D5, D6, D7, D8}, 4'b0000, -10, 16'h0, -10, 16'h0);
    wait_frame(n);
    check_frame("edge_hold", {D5, D6, D7, D8}, 4'b0000, -10, 16'h0, -10, 16'h0);

    // Async reset in the middle of digit 2
    wait_frame(n);
    repeat (13) @(negedge clk);
    chk("pre_reset_d2", outs(), {4'b1101, D7, 1'b1, 1'b0});
    reset = 1'b1;
    #1;
    chk("async_reset", outs(), ALL_OFF);
    release_and_check("rerun");
    check_frame("post_reset", {D0, D0, D0, D0}, 4'b0000, -10, 16'h0, -10, 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
